pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits; legal range 2..64.
REQ-002 SHALL have parameter STAGES, default 4: number of pipeline segments; WIDTH SHALL be an exact multiple of STAGES, and any other value is illegal and SHALL stop elaboration.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand set this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in (add mode) or borrow-in (subtract mode).
REQ-009 SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: result.
REQ-013 SHALL have port cout, output, 1 bit: carry-out of the MSB.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-015 Transfer rule: an input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 Add mode (sub=0): {cout,sum} SHALL equal a + b + cin, computed as a (WIDTH+1)-bit result.
REQ-017 Subtract mode (sub=1): the internal operand SHALL be ~b with carry-in ~cin, so that sum = a - b - cin mod 2^WIDTH and cout = 1 when no borrow occurs.
REQ-018 Segmentation: segment k SHALL add bits [k*W/S +: W/S] of the operands.
REQ-019 Carry path: each segment's carry SHALL be registered into segment k+1.
REQ-020 Skew handling: operand slices for later segments SHALL be delay-registered, and sum slices from earlier segments SHALL be delay-registered, so that all slices of one result align at the output.
REQ-021 Latency: out_valid SHALL assert exactly STAGES cycles after the accepting edge, provided there is no stall.
REQ-022 Throughput: the block SHALL sustain one transfer per cycle.
REQ-023 Pipeline advance: advance = !out_valid || out_ready, and in_ready SHALL equal advance.
REQ-024 Stall: when advance=0, every pipeline register, including the per-stage valid bits, SHALL hold.
REQ-025 No loss or duplication: results SHALL leave in acceptance order, with none lost and none duplicated.
REQ-026 Bubbles: a cycle with in_valid=0 while advance=1 SHALL inject a bubble whose valid bit is 0; bubbles SHALL collapse when out_ready=0 backs up the pipeline.
REQ-027 Simultaneous transfers: an input transfer and an output transfer in the same cycle SHALL both complete.
REQ-028 Hold rule: sum, cout and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 STAGES=1 SHALL degenerate to a single registered full-width add with latency 1.
REQ-030 Wrap-around: sum SHALL wrap modulo 2^WIDTH; cout and ovf SHALL report the wrap, and no saturation SHALL occur.

Reset
REQ-031 While rst=1 at a clock edge, all stage valid bits and out_valid SHALL be cleared to 0, and sum, cout and ovf SHALL be cleared to 0.
REQ-032 During rst=1, in_ready SHALL read 1; inputs presented in that cycle SHALL be discarded.
REQ-033 A reset asserted mid-operation SHALL discard all in-flight results, and no stale out_valid SHALL appear afterwards.

Configuration
REQ-034 The macro PIPELINED_ADDER_OVF_EN SHALL control overflow detection.
REQ-035 With PIPELINED_ADDER_OVF_EN defined, ovf SHALL equal (a_msb == b_eff_msb) && (sum_msb != a_msb), carried through the pipeline with its result.
REQ-036 Without PIPELINED_ADDER_OVF_EN, ovf SHALL be tied to 0, and no overflow logic or MSB delay registers SHALL be built.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-037 Carry propagation: a=FFFF, b=0001, cin=0, sub=0 -> 4 cycles later sum=0000, cout=1, ovf=0.
REQ-038 Subtract with borrow: a=0005, b=0007, cin=0, sub=1 -> sum=FFFE, cout=0, ovf=0.
REQ-039 Signed overflow: a=7FFF, b=0001, add -> sum=8000, cout=0; ovf=1 with the macro, ovf=0 without.
REQ-040 Backpressure: stream 8 back-to-back sets (a=i, b=i, i=1..8) with out_ready=0 from cycle 6 to cycle 12 -> in_ready falls, all 8 results (2,4,...,16) arrive in order with none dropped or repeated, and outputs are stable while stalled.
REQ-041 Reset mid-flight: accept 3 sets, assert rst for 1 cycle on the 2nd cycle after the first accept -> out_valid=0 for at least 4 cycles afterwards, and none of the 3 results emerges.
REQ-042 Exhaustive check: WIDTH=4, STAGES=2 and STAGES=1, all 512 combinations of a, b and cin in both modes -> every result matches a+b+cin or a-b-cin mod 16, with correct cout.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-registered
// segments, with valid/ready flow control and a single global stall.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_ready, a, b, cin, sub : operand side (sub=1 gives a-b-cin)
//   out_valid/out_ready, sum, cout, ovf : result side
// Build option: define PIPELINED_ADDER_OVF_EN to build two's-complement
// overflow detection; without it ovf is tied to 0.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SEG = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
   localparam int unsigned REM = (STAGES == 0) ? 1 : WIDTH % STAGES;

   // Stop elaboration on an illegal configuration
   if ((WIDTH < 2) || (WIDTH > 64) || (STAGES == 0) || (REM != 0)) begin : g_bad_cfg
      $error("pipelined_adder: illegal WIDTH/STAGES combination");
   end

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             adv;

   // Subtract is a + ~b + ~cin; the whole pipeline moves or holds together
   always_comb begin
      b_eff   = sub ? ~b : b;
      cin_eff = cin ^ sub;
      adv     = !out_valid || out_ready;
   end

   assign in_ready = rst || adv;

   for (genvar g = 0; g < STAGES; g++) begin : g_stg
      localparam int unsigned SW = (g + 1) * SEG;   // sum bits resolved so far
      localparam int unsigned PW = WIDTH - g * SEG; // operand bits entering this stage

      logic [SEG-1:0] a_seg;
      logic [SEG-1:0] b_seg;
      logic           cin_seg;
      logic [SEG:0]   seg_res;
      logic           valid_d, valid_q;
      logic           carry_d, carry_q;
      logic [SW-1:0]  sum_d, sum_q;

      // Segment operands come from the inputs or from the previous stage's skew registers
      if (g == 0) begin : g_in
         always_comb begin
            a_seg   = a[SEG-1:0];
            b_seg   = b_eff[SEG-1:0];
            cin_seg = cin_eff;
            valid_d = in_valid;
            sum_d   = seg_res[SEG-1:0];
         end
      end else begin : g_in
         always_comb begin
            a_seg   = g_stg[g-1].g_op.opa_q[SEG-1:0];
            b_seg   = g_stg[g-1].g_op.opb_q[SEG-1:0];
            cin_seg = g_stg[g-1].carry_q;
            valid_d = g_stg[g-1].valid_q;
            sum_d   = {seg_res[SEG-1:0], g_stg[g-1].sum_q};
         end
      end

      // One segment of the ripple, carry registered into the next stage
      always_comb begin
         seg_res = {1'b0, a_seg} + {1'b0, b_seg} + (SEG + 1)'(cin_seg);
         carry_d = seg_res[SEG];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
         end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
         end
      end

      // Upper operand slices delayed until their segment is reached
      if (g < STAGES - 1) begin : g_op
         localparam int unsigned OW = WIDTH - SW;
         logic [OW-1:0] opa_d, opa_q;
         logic [OW-1:0] opb_d, opb_q;

         if (g == 0) begin : g_src
            always_comb begin
               opa_d = a[WIDTH-1:SEG];
               opb_d = b_eff[WIDTH-1:SEG];
            end
         end else begin : g_src
            always_comb begin
               opa_d = g_stg[g-1].g_op.opa_q[PW-1:SEG];
               opb_d = g_stg[g-1].g_op.opb_q[PW-1:SEG];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               opa_q <= '0;
               opb_q <= '0;
            end else if (adv) begin
               opa_q <= opa_d;
               opb_q <= opb_d;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].valid_q;
   assign sum       = g_stg[STAGES-1].sum_q;
   assign cout      = g_stg[STAGES-1].carry_q;

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_d, ovf_q;

   // MSB operands are only present in the last segment, so overflow is judged there
   always_comb begin
      ovf_d = (g_stg[STAGES-1].a_seg[SEG-1] == g_stg[STAGES-1].b_seg[SEG-1]) &&
              (g_stg[STAGES-1].seg_res[SEG-1] != g_stg[STAGES-1].a_seg[SEG-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 16-bit/4-stage instance plus 4-bit instances with
// 2 stages and 1 stage. Results are checked against a queue of expected values
// filled on each input transfer and drained on each output transfer.
module tb_pipelined_adder;

   localparam int unsigned W = 16;
   localparam int unsigned S = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] a, b;
   logic        cin, sub;
   logic        out_valid, out_ready;
   logic [15:0] sum;
   logic        cout, ovf;

   logic        s_in_valid, s_out_ready;
   logic [3:0]  s_a, s_b;
   logic        s_cin, s_sub;
   logic        s2_in_ready, s2_out_valid, s2_cout, s2_ovf;
   logic [3:0]  s2_sum;
   logic        s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
   logic [3:0]  s1_sum;

   int          n_checks;
   int          n_pass;
   int          n_out;
   logic [17:0] q_main[$];
   logic [17:0] q_s2[$];
   logic [17:0] q_s1[$];
   bit          hold_pend;
   logic [17:0] hold_val;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipelined_adder #(.WIDTH(4), .STAGES(2)) u_dut_s2 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s2_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
      .out_valid(s2_out_valid), .out_ready(s_out_ready),
      .sum(s2_sum), .cout(s2_cout), .ovf(s2_ovf)
   );

   pipelined_adder #(.WIDTH(4), .STAGES(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s1_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
      .out_valid(s1_out_valid), .out_ready(s_out_ready),
      .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Arithmetic reference on plain integers: returns {ovf, cout, 16-bit sum}
   function automatic logic [17:0] model(input int unsigned w, input logic [15:0] av,
                                         input logic [15:0] bv, input logic ci, input logic s);
      longint m, r, ua, ub, uc, sa, sb, sr;
      logic   co, ov;
      m  = longint'(1) << w;
      ua = longint'(av);
      ub = longint'(bv);
      uc = ci ? 64'sd1 : 64'sd0;
      if (s) begin
         r  = ua - ub - uc;
         co = (ua >= ub + uc);
      end else begin
         r  = ua + ub + uc;
         co = (r >= m);
      end
      r  = ((r % m) + m) % m;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      sr = s ? (sa - sb - uc) : (sa + sb + uc);
      ov = (sr >= m / 2) || (sr < -(m / 2));
`ifndef PIPELINED_ADDER_OVF_EN
      ov = 1'b0;
`endif
      return {ov, co, 16'(r)};
   endfunction

   // Scoreboard, sampled on the falling edge when all handshakes are settled
   always @(negedge clk) begin
      if (rst) begin
         q_main.delete();
         q_s2.delete();
         q_s1.delete();
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({ovf, cout, sum}), 64'(hold_val));
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (q_main.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
            else check("result", 64'({ovf, cout, sum}), 64'(q_main.pop_front()));
         end
         hold_pend = out_valid && !out_ready;
         hold_val  = {ovf, cout, sum};
         if (in_valid && in_ready) q_main.push_back(model(W, a, b, cin, sub));

         if (s2_out_valid && s_out_ready) begin
            if (q_s2.size() == 0) check("s2_unexpected_out", 64'(s2_out_valid), 64'd0);
            else check("s2_result", 64'({s2_ovf, s2_cout, 12'd0, s2_sum}), 64'(q_s2.pop_front()));
         end
         if (s1_out_valid && s_out_ready) begin
            if (q_s1.size() == 0) check("s1_unexpected_out", 64'(s1_out_valid), 64'd0);
            else check("s1_result", 64'({s1_ovf, s1_cout, 12'd0, s1_sum}), 64'(q_s1.pop_front()));
         end
         if (s_in_valid && s2_in_ready) q_s2.push_back(model(4, 16'(s_a), 16'(s_b), s_cin, s_sub));
         if (s_in_valid && s1_in_ready) q_s1.push_back(model(4, 16'(s_a), 16'(s_b), s_cin, s_sub));
      end
   end

   // One isolated operand set; measures cycles from presentation to out_valid
   task automatic send_one(input logic [15:0] av, input logic [15:0] bv,
                           input logic ci, input logic s);
      int n;
      a = av; b = bv; cin = ci; sub = s; in_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         n++;
         @(negedge clk);
      end while (!out_valid && n < 20);
      check("latency", 64'(n), 64'(S));
      @(posedge clk); #1;
   endtask

   initial begin
      int  idx;
      int  n_before;
      bit  saw_stall;
      bit  xfer;
      n_checks = 0; n_pass = 0; n_out = 0;
      rst = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0;
      s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;

      // Reset with an operand set presented; it must be discarded
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'({ovf, cout, sum}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("post_rst_idle", 64'(out_valid), 64'd0);
         @(posedge clk); #1;
      end

      // Directed corner cases
      send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      send_one(16'h0005, 16'h0007, 1'b0, 1'b1);
      send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send_one(16'h8000, 16'h0001, 1'b0, 1'b1);
      send_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      send_one(16'h0000, 16'h0000, 1'b1, 1'b1);

      // Backpressure: 8 back-to-back sets, out_ready low for cycles 6..12
      idx = 0; saw_stall = 1'b0; n_before = n_out;
      for (int c = 0; c < 60 && (idx < 8 || q_main.size() != 0); c++) begin
         out_ready = !(c >= 6 && c <= 12);
         in_valid  = (idx < 8);
         a = 16'(idx + 1); b = 16'(idx + 1); cin = 1'b0; sub = 1'b0;
         @(negedge clk);
         if (in_valid && !in_ready) saw_stall = 1'b1;
         xfer = in_valid && in_ready;
         @(posedge clk); #1;
         if (xfer) idx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_in_ready_fell", 64'(saw_stall), 64'd1);
      check("bp_all_sent", 64'(idx), 64'd8);
      check("bp_n_out", 64'(n_out - n_before), 64'd8);

      // Reset mid-flight: three accepted sets must never emerge
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = 16'(100 + k); b = 16'h0001; cin = 1'b0; sub = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rst_flush_valid", 64'(out_valid), 64'd0);
         @(posedge clk); #1;
      end

      // Random traffic with random backpressure and corner operands
      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         case ($urandom_range(4))
            0: a = 16'hFFFF;
            1: a = 16'h7FFF;
            2: a = 16'h8000;
            default: a = 16'($urandom);
         endcase
         b   = ($urandom_range(3) == 0) ? 16'h0001 : 16'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && q_main.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      check("drain_main", 64'(q_main.size()), 64'd0);

      // Exhaustive 4-bit sweep on the 2-stage and 1-stage instances
      s_in_valid = 1'b1;
      for (int m = 0; m < 2; m++)
         for (int ci = 0; ci < 2; ci++)
            for (int x = 0; x < 16; x++)
               for (int y = 0; y < 16; y++) begin
                  s_sub = 1'(m); s_cin = 1'(ci); s_a = 4'(x); s_b = 4'(y);
                  @(posedge clk); #1;
               end
      s_in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("drain_s2", 64'(q_s2.size()), 64'd0);
      check("drain_s1", 64'(q_s1.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
